// File: rtl/apb_completer_regs_pkg.sv
// Shared types and helpers for the APB completer register block:
// FSM state encoding, pprot bit positions and the byte strobe merge.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam int PPROT_PRIV  = 0;
   localparam int PPROT_NSEC  = 1;
   localparam int PPROT_INSTR = 2;

   // Returns the new byte when its strobe is set, otherwise keeps the old one.
   function automatic logic [7:0] strb_merge_byte(input logic [7:0] old_byte,
                                                  input logic [7:0] new_byte,
                                                  input logic       strb);
      logic [7:0] res;
      if (strb) begin
         res = new_byte;
      end else begin
         res = old_byte;
      end
      return res;
   endfunction

endpackage

// File: rtl/apb_completer_regs_if.sv
// APB bus bundle between a requester (master) and a completer (slave).
interface apb_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) ();

   logic [ADDR_WIDTH-1:0]   paddr;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic [2:0]              pprot;
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic                    pready;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pslverr;

   modport master (
      output paddr, pwdata, pstrb, pprot, psel, penable, pwrite,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  paddr, pwdata, pstrb, pprot, psel, penable, pwrite,
      output pready, prdata, pslverr
   );

endinterface

// File: rtl/apb_wait_counter.sv
// ACCESS-phase wait counter: cleared outside ACCESS, counts up while enabled,
// and holds once it reaches WAIT_STATES.
module apb_wait_counter #(
   parameter int WAIT_STATES = 0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic done_o
);

   localparam int CNT_W = 4;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign done_o = (cnt_q == CNT_W'(WAIT_STATES));

   // Next count: clear wins, then saturating increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (enable_i && !done_o) begin
         cnt_d = cnt_q + 4'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/apb_completer_regs.sv
// APB completer with NUM_REGS byte-strobed registers and optional wait states.
// Build option: define APB_PPROT_CHECK_EN to reject unprivileged accesses to indices >= PRIV_BASE.
module apb_completer_regs
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_STATES = 0,
   parameter int PRIV_BASE   = 8
) (
   input  logic                           pclk,
   input  logic                           presetn,
   apb_if.slave                           apb,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int OFFS   = $clog2(NBYTES);
   localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   apb_state_e state_q;
   apb_state_e state_d;

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;

   logic [ADDR_WIDTH-1:0] word_idx_s;
   logic [IDX_W-1:0]      reg_idx_s;
   logic [DATA_WIDTH-1:0] wr_word_s;
   logic                  access_s;
   logic                  wait_done_s;
   logic                  done_s;
   logic                  addr_err_s;
   logic                  prot_err_s;
   logic                  err_s;
   logic                  commit_s;
   logic                  unused_s;

   assign word_idx_s = apb.paddr >> OFFS;
   assign reg_idx_s  = word_idx_s[IDX_W-1:0];
   assign addr_err_s = (word_idx_s >= ADDR_WIDTH'(NUM_REGS)) ||
                       ((apb.paddr & ADDR_WIDTH'(NBYTES - 1)) != {ADDR_WIDTH{1'b0}});

`ifdef APB_PPROT_CHECK_EN
   assign prot_err_s = !apb.pprot[PPROT_PRIV] && (word_idx_s >= ADDR_WIDTH'(PRIV_BASE));
   assign unused_s   = ^{apb.pprot[PPROT_NSEC], apb.pprot[PPROT_INSTR]};
`else
   assign prot_err_s = 1'b0;
   assign unused_s   = ^{apb.pprot[PPROT_PRIV], apb.pprot[PPROT_NSEC],
                         apb.pprot[PPROT_INSTR], 1'(PRIV_BASE)};
`endif

   assign access_s    = (state_q == ST_ACCESS);
   assign done_s      = access_s && wait_done_s;
   assign err_s       = addr_err_s || prot_err_s;
   // A requester that has already dropped psel gets no write, even on the done cycle.
   assign commit_s    = done_s && apb.psel && apb.pwrite && !err_s;
   assign apb.pready  = done_s;
   assign apb.pslverr = done_s && err_s;
   assign reg_out     = regs_q;

   apb_wait_counter #(
      .WAIT_STATES (WAIT_STATES)
   ) u_wait (
      .clk_i    (pclk),
      .rst_ni   (presetn),
      .clear_i  (!access_s),
      .enable_i (access_s),
      .done_o   (wait_done_s)
   );

   // Next-state logic for the IDLE/SETUP/ACCESS sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (apb.psel && !apb.penable) begin
               state_d = ST_SETUP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (!apb.psel) begin
               state_d = ST_IDLE;
            end else if (apb.penable) begin
               state_d = ST_ACCESS;
            end else begin
               state_d = ST_SETUP;
            end
         end
         ST_ACCESS: begin
            if (!apb.psel) begin
               state_d = ST_IDLE;
            end else if (wait_done_s) begin
               if (!apb.penable) begin
                  state_d = ST_SETUP;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_ACCESS;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Merge write data into the addressed word under the byte strobes.
   always_comb begin
      wr_word_s = regs_q[reg_idx_s];
      for (int b = 0; b < NBYTES; b++) begin
         wr_word_s[8*b +: 8] = strb_merge_byte(regs_q[reg_idx_s][8*b +: 8],
                                               apb.pwdata[8*b +: 8], apb.pstrb[b]);
      end
   end

   // Register file; only an error-free completing write changes it.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         regs_q <= '0;
      end else if (commit_s) begin
         regs_q[reg_idx_s] <= wr_word_s;
      end else begin
         regs_q <= regs_q;
      end
   end

   // Read data is only driven on an error-free read completion.
   always_comb begin
      apb.prdata = {DATA_WIDTH{1'b0}};
      if (done_s && !apb.pwrite && !err_s) begin
         apb.prdata = regs_q[reg_idx_s];
      end else begin
         apb.prdata = {DATA_WIDTH{1'b0}};
      end
   end

endmodule

// File: doc/apb_completer_regs.md
APB_COMPLETER_REGS -- requirements
Module: apb_completer_regs

Interface
REQ-001 ADDR_WIDTH, 32, paddr width SHALL be parametrised.
REQ-002 DATA_WIDTH, 32, data width in bits, multiple of 8, SHALL be parametrised.
REQ-003 NUM_REGS, 16, number of DATA_WIDTH registers SHALL be parametrised.
REQ-004 WAIT_STATES, 0, extra ACCESS cycles before pready SHALL be parametrised (0..15).
REQ-005 PRIV_BASE, 8, first privileged register index SHALL be parametrised.
REQ-006 pclk  in  1  single clock; all state SHALL change on its rising edge.
REQ-007 presetn  in  1  reset, asynchronous, active-low.
REQ-008 paddr  in  ADDR_WIDTH  byte address.
REQ-009 pwdata  in  DATA_WIDTH  write data.
REQ-010 pstrb  in  DATA_WIDTH/8  byte write strobes.
REQ-011 pprot  in  3  protection type.
REQ-012 psel  in  1  select.
REQ-013 penable  in  1  access phase.
REQ-014 pwrite  in  1  1 = write, 0 = read.
REQ-015 pready  out  1  transfer complete.
REQ-016 prdata  out  DATA_WIDTH  read data.
REQ-017 pslverr  out  1  transfer error, valid only with pready.
REQ-018 reg_out  out  NUM_REGS*DATA_WIDTH  flat register contents, reg 0 in the LSBs.

Function
REQ-019 The FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-020 IDLE->SETUP on psel&!penable; penable high in IDLE SHALL be ignored.
REQ-021 SETUP->ACCESS on psel&penable; SETUP->IDLE on !psel (abort, no effect).
REQ-022 In ACCESS a wait counter SHALL start at 0, increment each cycle, and pready SHALL be combinational: (state==ACCESS)&&(cnt==WAIT_STATES).
REQ-023 With WAIT_STATES=0, pready SHALL assert in the first ACCESS cycle (two-cycle transfer).
REQ-024 After the pready cycle the FSM SHALL go to SETUP if psel&!penable, else IDLE.
REQ-025 If psel drops in ACCESS before pready, the FSM SHALL return to IDLE with no register update.
REQ-026 Register index SHALL be paddr>>log2(DATA_WIDTH/8); pslverr SHALL assert with pready if index>=NUM_REGS or paddr is not word-aligned.
REQ-027 Write SHALL commit on the pready edge only when pslverr=0, updating byte k only when pstrb[k]=1; pstrb=0 SHALL leave the register unchanged without error.
REQ-028 prdata SHALL equal the addressed register during a read pready cycle without error, else 0.
REQ-029 Address, data and control SHALL be sampled from the live bus during ACCESS; changes during wait states are a master violation and need no defined handling.

Reset
REQ-030 presetn low SHALL immediately force state IDLE, cnt 0, all registers 0, pready 0, pslverr 0, prdata 0.
REQ-031 Reset mid-ACCESS SHALL abort the transfer with no partial write.

Configuration
REQ-032 With APB_PPROT_CHECK_EN defined, an access with pprot[0]=0 to an index >= PRIV_BASE SHALL complete with pslverr=1, no write, and prdata 0.
REQ-033 Without APB_PPROT_CHECK_EN, pprot SHALL be ignored and PRIV_BASE SHALL be unused.

Structure
REQ-034 Package apb_pkg SHALL hold the FSM state enum, the pprot bit-position constants (PPROT_PRIV=0, PPROT_NSEC=1, PPROT_INSTR=2) and a strobe-merge function.
REQ-035 The wait counter SHALL be sub-module apb_wait_counter (clear, enable, done at WAIT_STATES).

Verification
REQ-036 WAIT_STATES=0: write 0xDEADBEEF to 0x04 with pstrb=0xF, then read 0x04 -> pready in the 2nd cycle of each transfer, prdata=0xDEADBEEF, pslverr=0.
REQ-037 Register 0x08 holds 0x11223344; write 0xAABBCCDD with pstrb=0x5 -> read returns 0x11BB33DD.
REQ-038 WAIT_STATES=3: read 0x00 -> pready on the 4th ACCESS cycle, pready=0 before that.
REQ-039 Write to 0x40 (index 16, NUM_REGS=16) and to 0x02 -> pslverr=1 with pready, reg_out unchanged.
REQ-040 APB_PPROT_CHECK_EN: write 0x1 to 0x20 with pprot=3'b000 -> pslverr=1, no write; same write with pprot=3'b001 -> pslverr=0, register=0x1.
REQ-041 Assert presetn low during the 2nd wait cycle of a write -> pready=0, target register remains 0, FSM in IDLE.
